multi_cycle_core: RTL



---
 rtl/multi_cycle_core.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_core.sv
// ============================================================================
// Module   : multi_cycle_core
// Brief    : Multi-cycle RV32I-subset core (R/I ALU, lw, sw, beq) sharing one
//            req/ready memory port between instruction fetch and data access.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic [31:0] pc_out
);

    localparam logic [31:0] c_RESET_PC  = RESET_PC & ~32'h3;
    localparam logic [6:0]  c_OP_R      = 7'b0110011;
    localparam logic [6:0]  c_OP_I      = 7'b0010011;
    localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
    localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_old_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_alu_out;
    logic [31:0] r_mdr;
    logic [31:0] r_regs [0:31];

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic        w_is_sub;
    logic        w_legal;
    logic        w_mem_phase;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_funct3 = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_funct7 = r_ir[31:25];

    assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

    // Decode only ever lets legal encodings reach EXEC, so the ALU decodes on funct3 alone.
    always_comb begin
        w_alu_b      = (w_opcode == c_OP_R) ? r_b : w_imm_i;
        w_is_sub     = (w_opcode == c_OP_R) && w_funct7[5];
        w_alu_result = r_a + w_alu_b;
        case (w_funct3)
            3'b000:  w_alu_result = w_is_sub ? (r_a - w_alu_b) : (r_a + w_alu_b);
            3'b100:  w_alu_result = r_a ^ w_alu_b;
            3'b110:  w_alu_result = r_a | w_alu_b;
            3'b111:  w_alu_result = r_a & w_alu_b;
            3'b010:  w_alu_result = {31'd0, ($signed(r_a) < $signed(w_alu_b))};
            default: w_alu_result = r_a + w_alu_b;
        endcase
    end

    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                case (w_funct3)
                    3'b000:                      w_legal = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
                    3'b100, 3'b110, 3'b111, 3'b010: w_legal = (w_funct7 == 7'h00);
                    default:                     w_legal = 1'b0;
                endcase
            end
            c_OP_I: begin
                case (w_funct3)
                    3'b000, 3'b100, 3'b110, 3'b111, 3'b010: w_legal = 1'b1;
                    default:                              w_legal = 1'b0;
                endcase
            end
            c_OP_LOAD, c_OP_STORE: w_legal = (w_funct3 == 3'b010);
            c_OP_BRANCH:           w_legal = (w_funct3 == 3'b000);
            default:               w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= c_RESET_PC;
            r_old_pc  <= 32'd0;
            r_ir      <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_alu_out <= 32'd0;
            r_mdr     <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir     <= mem_rdata;
                        r_old_pc <= r_pc;
                        r_pc     <= r_pc + 32'd4;
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a <= w_rs1_val;
                    r_b <= w_rs2_val;
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                end
                S_EXEC: begin
                    case (w_opcode)
                        c_OP_R, c_OP_I: begin
                            r_alu_out <= w_alu_result;
                            r_state   <= S_WB;
                        end
                        c_OP_LOAD: begin
                            r_alu_out <= r_a + w_imm_i;
                            r_state   <= S_MEM;
                        end
                        c_OP_STORE: begin
                            r_alu_out <= r_a + w_imm_s;
                            r_state   <= S_MEM;
                        end
                        default: begin
                            // Branch target is relative to the fetched instruction, word aligned.
                            if (r_a == r_b) begin
                                r_pc <= (r_old_pc + w_imm_b) & ~32'h3;
                            end
                            r_state <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_opcode == c_OP_LOAD) begin
                            r_mdr   <= mem_rdata;
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (w_rd != 5'd0) begin
                        r_regs[w_rd] <= (w_opcode == c_OP_LOAD) ? r_mdr : r_alu_out;
                    end
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Reset gates the bus combinationally so an in-flight transfer is dropped immediately.
    assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
    assign mem_req     = w_mem_phase && !rst;
    assign mem_we      = !rst && (r_state == S_MEM) && (w_opcode == c_OP_STORE);
    assign mem_addr    = (r_state == S_MEM) ? {r_alu_out[31:2], 2'b00} : r_pc;
    assign mem_wdata   = rst ? 32'd0 : r_b;
    assign halted      = !rst && (r_state == S_HALT);
    assign pc_out      = rst ? c_RESET_PC : r_pc;

endmodule

`default_nettype wire
